scr1_tcm_dport_ctrl: RTL and testbench

Data-side front-end for the TCM dual-port memory's port B. It sits between the core's dmem request/ack interface and the memory's port B pins (renb/wenb/webb/addrb/datab/qb). It decodes and validates byte, halfword and word accesses, generates byte enables and lane-replicated write data, and aligns read data. It returns a single-cycle response and captures the first faulting access for debug.

---
 rtl/scr1_tcm_dport_ctrl.sv | 141 ++++++++++++++
 tb/tb_scr1_tcm_dport_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_tcm_dport_ctrl.sv
// TCM port B data-side front-end: validates dmem accesses, drives byte-lane writes,
// aligns registered read data, and latches the first faulting address.
`timescale 1ns/1ps

module scr1_tcm_dport_ctrl #(
  parameter int          SCR1_WIDTH  = 32,
  parameter int unsigned SCR1_SIZE   = 32'h00010000,
  parameter int          SCR1_NBYTES = SCR1_WIDTH / 8,
  parameter int          AW          = $clog2(SCR1_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dmem_req,
  input  logic                   dmem_cmd,
  input  logic [1:0]             dmem_width,
  input  logic [31:0]            dmem_addr,
  input  logic [SCR1_WIDTH-1:0]  dmem_wdata,
  output logic                   dmem_req_ack,
  output logic [SCR1_WIDTH-1:0]  dmem_rdata,
  output logic [1:0]             dmem_resp,
  output logic                   renb,
  output logic                   wenb,
  output logic [SCR1_NBYTES-1:0] webb,
  output logic [AW-3:0]          addrb,
  output logic [SCR1_WIDTH-1:0]  datab,
  input  logic [SCR1_WIDTH-1:0]  qb,
  output logic                   err_valid,
  output logic [31:0]            err_addr,
  input  logic                   err_clr
);

  localparam logic [1:0] RESP_IDLE = 2'd0;
  localparam logic [1:0] RESP_RDY  = 2'd1;
  localparam logic [1:0] RESP_ER   = 2'd2;

  localparam logic [1:0] W_BYTE = 2'd0;
  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_WORD = 2'd2;

  logic                  accept;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  fault;
  logic                  legal;
  logic [1:0]            off;

  logic [1:0]            resp_q;
  logic                  rd_q;
  logic [1:0]            off_q;
  logic [1:0]            width_q;
  logic [SCR1_WIDTH-1:0] shifted;

  assign accept       = dmem_req & ~rst;
  assign dmem_req_ack = accept;
  assign off          = dmem_addr[1:0];

  always_comb begin
    misaligned = 1'b0;
    case (dmem_width)
      W_HALF:  misaligned = off[0];
      W_WORD:  misaligned = (off != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  // Any address bit at or above AW lies outside the TCM window.
  assign out_of_range = (dmem_addr >> AW) != '0;
  assign fault        = accept & ((dmem_width == 2'b11) | misaligned | out_of_range);
  assign legal        = accept & ~fault;

  assign renb  = legal & ~dmem_cmd;
  assign wenb  = legal & dmem_cmd;
  assign addrb = legal ? dmem_addr[AW-1:2] : '0;

  always_comb begin
    webb  = '0;
    datab = '0;
    if (wenb) begin
      case (dmem_width)
        W_BYTE: begin
          webb  = 4'b0001 << off;
          datab = {4{dmem_wdata[7:0]}};
        end
        W_HALF: begin
          webb  = 4'b0011 << off;
          datab = {2{dmem_wdata[15:0]}};
        end
        default: begin
          webb  = '1;
          datab = dmem_wdata;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_q  <= RESP_IDLE;
      rd_q    <= 1'b0;
      off_q   <= '0;
      width_q <= '0;
    end else begin
      resp_q <= accept ? (fault ? RESP_ER : RESP_RDY) : RESP_IDLE;
      rd_q   <= renb;
      if (renb) begin
        off_q   <= off;
        width_q <= dmem_width;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
    end else if (err_clr) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
    end else if (fault && !err_valid) begin
      err_valid <= 1'b1;
      err_addr  <= dmem_addr;
    end
  end

  // qb arrives in the response cycle, so alignment is combinational on the registered offset.
  assign shifted = qb >> {off_q, 3'b000};

  always_comb begin
    dmem_rdata = '0;
    if (rd_q) begin
      case (width_q)
        W_BYTE:  dmem_rdata = {24'h0, shifted[7:0]};
        W_HALF:  dmem_rdata = {16'h0, shifted[15:0]};
        default: dmem_rdata = shifted;
      endcase
    end
  end

  assign dmem_resp = resp_q;

endmodule

// File: tb/tb_scr1_tcm_dport_ctrl.sv
// Directed bench for scr1_tcm_dport_ctrl with a byte-level reference model and
// a port-B memory that answers reads one cycle after renb.
`timescale 1ns/1ps

module tb_scr1_tcm_dport_ctrl;

  localparam int unsigned SIZE = 32'h00010000;
  localparam int          AW   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dmem_req = 1'b0;
  logic        dmem_cmd = 1'b0;
  logic [1:0]  dmem_width = 2'd0;
  logic [31:0] dmem_addr = '0;
  logic [31:0] dmem_wdata = '0;
  logic        dmem_req_ack;
  logic [31:0] dmem_rdata;
  logic [1:0]  dmem_resp;
  logic        renb;
  logic        wenb;
  logic [3:0]  webb;
  logic [AW-3:0] addrb;
  logic [31:0] datab;
  logic [31:0] qb = '0;
  logic        err_valid;
  logic [31:0] err_addr;
  logic        err_clr = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  scr1_tcm_dport_ctrl #(
    .SCR1_WIDTH (32),
    .SCR1_SIZE  (SIZE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .dmem_req     (dmem_req),
    .dmem_cmd     (dmem_cmd),
    .dmem_width   (dmem_width),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_req_ack (dmem_req_ack),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .renb         (renb),
    .wenb         (wenb),
    .webb         (webb),
    .addrb        (addrb),
    .datab        (datab),
    .qb           (qb),
    .err_valid    (err_valid),
    .err_addr     (err_addr),
    .err_clr      (err_clr)
  );

  // Port B memory
  logic [31:0] pmem [0:(SIZE/4)-1];
  initial for (int unsigned i = 0; i < SIZE / 4; i++) pmem[i] = '0;

  always @(posedge clk) begin
    if (wenb)
      for (int unsigned i = 0; i < 4; i++)
        if (webb[i]) pmem[addrb][8*i +: 8] <= datab[8*i +: 8];
    if (renb) qb <= pmem[addrb];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference rules
  function automatic int unsigned acc_size(input logic [1:0] w);
    return 32'd1 << w;
  endfunction

  function automatic logic is_fault(input logic [1:0] w, input logic [31:0] a);
    if (w == 2'd3) return 1'b1;
    return ((a % acc_size(w)) != 0) || (a >= SIZE);
  endfunction

  function automatic logic [3:0] lanes(input logic [1:0] w, input logic [31:0] a);
    int unsigned off = a % 4;
    int unsigned sz  = acc_size(w);
    logic [3:0]  r   = '0;
    for (int unsigned i = 0; i < 4; i++) r[i] = (i >= off) && (i < off + sz);
    return r;
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] w, input logic [31:0] d);
    int unsigned sz = acc_size(w);
    logic [31:0] r  = '0;
    for (int unsigned i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
    return r;
  endfunction

  logic [7:0]  ref_mem [0:SIZE-1];
  initial for (int unsigned i = 0; i < SIZE; i++) ref_mem[i] = '0;

  logic [1:0]  m_resp  = 2'd0;
  logic [31:0] m_rdata = '0;
  logic        m_ev    = 1'b0;
  logic [31:0] m_ea    = '0;
  logic        m_f;
  logic [3:0]  m_ln;
  logic [31:0] m_ld;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_resp = 2'd0; m_rdata = '0; m_ev = 1'b0; m_ea = '0;
    end else begin
      m_f = dmem_req && is_fault(dmem_width, dmem_addr);
      m_rdata = '0;
      if (!dmem_req) m_resp = 2'd0;
      else if (m_f) m_resp = 2'd2;
      else if (!dmem_cmd) begin
        m_resp = 2'd1;
        for (int unsigned k = 0; k < acc_size(dmem_width); k++)
          m_rdata[8*k +: 8] = ref_mem[dmem_addr + k];
      end else begin
        m_resp = 2'd1;
        m_ln = lanes(dmem_width, dmem_addr);
        m_ld = lane_data(dmem_width, dmem_wdata);
        for (int unsigned i = 0; i < 4; i++)
          if (m_ln[i]) ref_mem[(dmem_addr & ~32'd3) + i] = m_ld[8*i +: 8];
      end
      if (err_clr) begin m_ev = 1'b0; m_ea = '0; end
      else if (m_f && !m_ev) begin m_ev = 1'b1; m_ea = dmem_addr; end
    end
  end

  logic c_ack, c_legal, c_wr;

  always @(negedge clk) begin
    c_ack   = dmem_req && !rst;
    c_legal = c_ack && !is_fault(dmem_width, dmem_addr);
    c_wr    = c_legal && dmem_cmd;
    check("ack",  32'(dmem_req_ack), 32'(c_ack));
    check("renb", 32'(renb), 32'(c_legal && !dmem_cmd));
    check("wenb", 32'(wenb), 32'(c_wr));
    check("webb", 32'(webb), c_wr ? 32'(lanes(dmem_width, dmem_addr)) : 32'd0);
    if (c_legal) check("addrb", 32'(addrb), dmem_addr >> 2);
    if (c_wr) check("datab", datab, lane_data(dmem_width, dmem_wdata));
    check("resp",      32'(dmem_resp), 32'(m_resp));
    check("rdata",     dmem_rdata, m_rdata);
    check("err_valid", 32'(err_valid), 32'(m_ev));
    check("err_addr",  err_addr, m_ea);
  end

  task automatic issue(input logic cmd, input logic [1:0] w, input logic [31:0] a,
                       input logic [31:0] d, input logic clr);
    @(posedge clk); #1;
    dmem_req = 1'b1; dmem_cmd = cmd; dmem_width = w;
    dmem_addr = a; dmem_wdata = d; err_clr = clr;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    dmem_req = 1'b0; dmem_cmd = 1'b0; dmem_width = 2'd0;
    dmem_addr = '0; dmem_wdata = '0; err_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Request held during reset must not be acknowledged
    dmem_req = 1'b1; dmem_width = 2'd2; dmem_addr = 32'h10;
    @(negedge clk);
    check("lit_rst_ack",  32'(dmem_req_ack), 32'd0);
    check("lit_rst_renb", 32'(renb), 32'd0);
    check("lit_rst_resp", 32'(dmem_resp), 32'd0);
    check("lit_rst_err",  32'(err_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; dmem_req = 1'b0;

    issue(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    check("lit_w_webb",  32'(webb), 32'hF);
    check("lit_w_addrb", 32'(addrb), 32'd4);
    for (int unsigned i = 0; i < 4; i++) issue(1'b0, 2'd0, 32'h10 + i, '0, 1'b0);
    idle();
    @(negedge clk);
    check("lit_rb3", dmem_rdata, 32'hDE);

    issue(1'b1, 2'd2, 32'h20, 32'hCAFEF00D, 1'b0);
    issue(1'b1, 2'd1, 32'h22, 32'h00001234, 1'b0);
    @(negedge clk);
    check("lit_h_webb",  32'(webb), 32'hC);
    check("lit_h_datab", datab, 32'h12341234);
    issue(1'b0, 2'd2, 32'h20, '0, 1'b0);
    idle();
    @(negedge clk);
    check("lit_h_rd", dmem_rdata, 32'h1234F00D);

    issue(1'b0, 2'd1, 32'h21, '0, 1'b0);
    @(negedge clk);
    check("lit_mis_renb", 32'(renb), 32'd0);
    issue(1'b0, 2'd2, 32'h06, '0, 1'b0);
    @(negedge clk);
    check("lit_mis_resp", 32'(dmem_resp), 32'd2);
    issue(1'b0, 2'd3, 32'h0, '0, 1'b0);
    issue(1'b0, 2'd2, SIZE, '0, 1'b0);
    @(negedge clk);
    check("lit_oor_renb", 32'(renb), 32'd0);
    check("lit_err_addr", err_addr, 32'h21);

    issue(1'b1, 2'd2, 32'hFFFC, 32'hA5A55A5A, 1'b0);
    issue(1'b0, 2'd2, 32'hFFFC, '0, 1'b0);
    idle();
    @(negedge clk);
    check("lit_top_rd", dmem_rdata, 32'hA5A55A5A);

    for (int unsigned i = 0; i < 4; i++) begin
      issue(1'b1, 2'd2, 32'h100 + 4 * i, 32'h11111111 * (i + 1), 1'b0);
      issue(1'b0, 2'd2, 32'h100 + 4 * i, '0, 1'b0);
    end
    idle();
    @(negedge clk);
    check("lit_b2b_rd", dmem_rdata, 32'h44444444);

    issue(1'b0, 2'd2, 32'h10004, '0, 1'b1);
    idle();
    @(negedge clk);
    check("lit_clr_ev", 32'(err_valid), 32'd0);
    check("lit_clr_ea", err_addr, 32'd0);

    issue(1'b0, 2'd2, 32'h10, '0, 1'b0);
    @(posedge clk); #1;
    dmem_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("lit_mid_rst_resp", 32'(dmem_resp), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("lit_no_replay", 32'(dmem_resp), 32'd0);
    issue(1'b0, 2'd2, 32'h10, '0, 1'b0);
    @(negedge clk);
    check("lit_post_ack", 32'(dmem_req_ack), 32'd1);
    idle();
    @(negedge clk);
    check("lit_post_resp", 32'(dmem_resp), 32'd1);
    check("lit_post_rd", dmem_rdata, 32'hDEADBEEF);
    idle();
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
